int_ack_seq: RTL
================

Name: int_ack_seq

Overview:
Interrupt acknowledge sequencer that sits directly downstream of the HVPISys priority interrupt block, between it and the CPU control unit. It consumes intPending/isrAddr and waits for an instruction boundary. It then acknowledges the interrupt by driving HVPISys clrPend (active-low), saves the return PC and flags, and loads the ISR entry PC. While the handler runs it holds intDisable high, and on return-from-interrupt it restores PC and flags.

Parameters:
VEC_BASE, 16'h0010, base address of the ISR jump table
VEC_SHIFT, 2, log2 of the byte spacing between jump-table entries
FLAG_W, 4, width of the CPU flag word saved and restored

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
intPending  in  1  from HVPISys: an unmasked interrupt is pending
isrAddr  in  16  from HVPISys: priority index, 1..4
instrDone  in  1  CPU is at an instruction boundary this cycle
retInt  in  1  CPU executed RETI (one-cycle strobe)
eiStrobe  in  1  enable-interrupts instruction strobe
diStrobe  in  1  disable-interrupts instruction strobe
curPC  in  16  CPU next-instruction PC
curFlags  in  FLAG_W  CPU flag word
clrPend  out  1  to HVPISys; active-low pending clear
intDisable  out  1  to HVPISys; active-high
stallCpu  out  1  freeze CPU fetch
pcLoad  out  1  load pcOut into the CPU PC this cycle
pcOut  out  16  PC value to load
flagsLoad  out  1  load flagsOut into the CPU flags
flagsOut  out  FLAG_W  restored flags
inService  out  1  handler active
retErr  out  1  sticky: RETI received while not in service
intCount  out  8  count of accepted interrupts, saturating

Behaviour:
- Reset (async, rst=1):
  - State=IDLE, gie=0.
  - Outputs: clrPend=1, intDisable=1, stallCpu=0, pcLoad=0, pcOut=0, flagsLoad=0, flagsOut=0, inService=0, retErr=0, intCount=0.
  - Internal savedPC, savedFlags and vecIdx are cleared.
- gie (global interrupt enable):
  - eiStrobe sets gie; diStrobe clears it.
  - If both strobes arrive together, di wins.
  - gie is only changed by the strobes (or reset); it is not altered by entering or leaving an ISR.
- intDisable = ~gie | (state != IDLE). It is registered, so it changes the cycle after the cause.
- States:
  - IDLE:
    - Accept when intPending & gie & instrDone & ~intDisable.
    - On accept: savedPC<=curPC, savedFlags<=curFlags, vecIdx<=isrAddr, intCount+=1 (saturates at 255); go to ACK.
    - retInt in IDLE: set retErr, no other effect.
  - ACK (1 cycle): clrPend=0, stallCpu=1, intDisable=1; go to VECTOR.
  - VECTOR (1 cycle):
    - pcLoad=1, stallCpu=1.
    - pcOut = VEC_BASE + ((vecIdx-1) << VEC_SHIFT), truncated to 16 bits; no range check (vecIdx=0 wraps).
    - Go to IN_SERVICE.
  - IN_SERVICE: inService=1, intDisable=1. intPending is ignored. retInt goes to RESTORE.
  - RESTORE (1 cycle): pcLoad=1, pcOut=savedPC, flagsLoad=1, flagsOut=savedFlags, stallCpu=1; go to IDLE.
- All outputs are registered and reflect the current state.
- Latency: an accept at edge N gives clrPend low in cycle N+1, pcLoad in N+2, and inService in N+3. retInt at edge M gives restore pcLoad in M+1; intDisable falls in M+2 if gie=1.
- Boundary cases:
  - Back-to-back: if another interrupt is pending right after RESTORE, it is accepted no earlier than one IDLE cycle in which intDisable=0 has been visible to HVPISys.
  - intPending dropping after the accept cycle does not abort the sequence.
  - Reset mid-sequence returns to IDLE immediately, with no restore.
  - retInt during ACK or VECTOR is ignored (CPU is stalled).
  - isrAddr is sampled only on accept.

Test Plan:
- Reset, then eiStrobe; intPending=1, isrAddr=3, instrDone=1, curPC=0x1234, curFlags=4'b1010 -> clrPend=0 for exactly one cycle, then pcLoad=1 with pcOut=0x0018, then inService=1, intDisable=1, intCount=1.
- From in-service, retInt=1 -> pcOut=0x1234 and flagsOut=4'b1010 with pcLoad=flagsLoad=1 for one cycle; inService=0; intDisable=0 one cycle later.
- gie=0 (no eiStrobe), intPending=1, instrDone=1 for 20 cycles -> no clrPend pulse, pcLoad stays 0, intDisable=1.
- eiStrobe and diStrobe asserted together, then a pending interrupt -> gie=0 and the interrupt is not accepted. retInt while IDLE -> retErr=1 and stays 1 until reset.
- Assert rst during IN_SERVICE -> all outputs return to reset values asynchronously. A later interrupt with isrAddr=1 vectors to pcOut=0x0010.
- 256 accept/return sequences -> intCount saturates at 255. isrAddr=4 -> pcOut=0x001C.

Source files
------------

// File: rtl/int_ack_seq_if.sv
// Signal bundle between the interrupt acknowledge sequencer, HVPISys and the CPU control unit.
// The slave modport is the sequencer's view. The master modport is the view of the HVPISys/CPU side.
interface int_ack_seq_if #(
  parameter int unsigned FLAG_W = 4
);
  logic              intPending;
  logic [15:0]       isrAddr;
  logic              instrDone;
  logic              retInt;
  logic              eiStrobe;
  logic              diStrobe;
  logic [15:0]       curPC;
  logic [FLAG_W-1:0] curFlags;
  logic              clrPend;
  logic              intDisable;
  logic              stallCpu;
  logic              pcLoad;
  logic [15:0]       pcOut;
  logic              flagsLoad;
  logic [FLAG_W-1:0] flagsOut;
  logic              inService;
  logic              retErr;
  logic [7:0]        intCount;

  modport master (
    output intPending, isrAddr, instrDone, retInt, eiStrobe, diStrobe, curPC, curFlags,
    input  clrPend, intDisable, stallCpu, pcLoad, pcOut, flagsLoad, flagsOut,
           inService, retErr, intCount
  );

  modport slave (
    input  intPending, isrAddr, instrDone, retInt, eiStrobe, diStrobe, curPC, curFlags,
    output clrPend, intDisable, stallCpu, pcLoad, pcOut, flagsLoad, flagsOut,
           inService, retErr, intCount
  );
endinterface

// File: rtl/int_ack_seq.sv
// Interrupt acknowledge sequencer. It accepts a pending HVPISys interrupt at an instruction boundary,
// vectors the CPU to the ISR, and restores the PC and flags on RETI.
module int_ack_seq #(
  parameter logic [15:0] VEC_BASE  = 16'h0010,
  parameter int unsigned VEC_SHIFT = 2,
  parameter int unsigned FLAG_W    = 4
) (
  input logic         clk,
  input logic         rst,
  int_ack_seq_if.slave bus
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] ACK        = 3'd1;
  localparam logic [2:0] VECTOR     = 3'd2;
  localparam logic [2:0] IN_SERVICE = 3'd3;
  localparam logic [2:0] RESTORE    = 3'd4;

  logic [2:0]        state;
  logic [2:0]        stateNext;
  logic              gie;
  logic              gieNext;
  logic              accept;
  logic [15:0]       savedPC;
  logic [FLAG_W-1:0] savedFlags;
  logic [15:0]       vecIdx;
  logic [15:0]       vecPC;

  // If both strobes arrive in the same cycle, the disable strobe wins.
  always_comb begin
    gieNext = gie;
    if (bus.diStrobe)
      gieNext = 1'b0;
    else if (bus.eiStrobe)
      gieNext = 1'b1;
  end

  // Gating on the registered intDisable forces at least one idle cycle, visible to HVPISys, between ISRs.
  assign accept = (state == IDLE) & bus.intPending & gie & bus.instrDone & ~bus.intDisable;

  assign vecPC = VEC_BASE + ((vecIdx - 16'd1) << VEC_SHIFT);

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:       if (accept) stateNext = ACK;
      ACK:        stateNext = VECTOR;
      VECTOR:     stateNext = IN_SERVICE;
      IN_SERVICE: if (bus.retInt) stateNext = RESTORE;
      RESTORE:    stateNext = IDLE;
      default:    stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gie        <= 1'b0;
      savedPC    <= '0;
      savedFlags <= '0;
      vecIdx     <= '0;
      bus.intCount <= '0;
      bus.retErr   <= 1'b0;
    end else begin
      state <= stateNext;
      gie   <= gieNext;
      if (accept) begin
        savedPC    <= bus.curPC;
        savedFlags <= bus.curFlags;
        vecIdx     <= bus.isrAddr;
        if (bus.intCount != 8'hFF)
          bus.intCount <= bus.intCount + 8'd1;
      end
      if ((state == IDLE) && bus.retInt)
        bus.retErr <= 1'b1;
    end
  end

  // The outputs are decoded from the next state, so they are registered and track the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.clrPend    <= 1'b1;
      bus.intDisable <= 1'b1;
      bus.stallCpu   <= 1'b0;
      bus.pcLoad     <= 1'b0;
      bus.pcOut      <= '0;
      bus.flagsLoad  <= 1'b0;
      bus.flagsOut   <= '0;
      bus.inService  <= 1'b0;
    end else begin
      bus.clrPend    <= (stateNext != ACK);
      bus.intDisable <= ~gieNext | (stateNext != IDLE);
      bus.stallCpu   <= (stateNext == ACK) || (stateNext == VECTOR) || (stateNext == RESTORE);
      bus.pcLoad     <= (stateNext == VECTOR) || (stateNext == RESTORE);
      bus.flagsLoad  <= (stateNext == RESTORE);
      bus.inService  <= (stateNext == IN_SERVICE);
      unique case (stateNext)
        VECTOR:  bus.pcOut <= vecPC;
        RESTORE: bus.pcOut <= savedPC;
        default: bus.pcOut <= '0;
      endcase
      bus.flagsOut <= (stateNext == RESTORE) ? savedFlags : '0;
    end
  end

endmodule
